// File: rtl/cpu_result_checker.sv
// rtl/cpu_result_checker.sv - CPU self-test sequencer: reset/start the CPU, wait for ack, check a DM result window
//
// Purpose:
//   Drives the CPU reset/start handshake, waits for the program-complete
//   acknowledge (bounded by TIMEOUT), then reads NUM_TESTS consecutive data
//   memory words starting at RES_BASE and compares each against a loadable
//   expected table. Reports pass/fail counts and the first mismatching word.
//
// Ports:
//   clk            - single clock, all logic on posedge
//   reset          - synchronous active-low reset
//   go             - single-cycle campaign request (honoured in IDLE/DONE only)
//   exp_we         - expected-table write enable (honoured in IDLE/DONE only)
//   exp_idx        - expected-table write index
//   exp_data       - expected value to write
//   cpu_reset      - active-high reset to the CPU
//   cpu_start      - start request to the CPU
//   cpu_ack        - CPU program-complete flag
//   dm_rd_addr     - data memory read address (RES_BASE+idx, wraps mod 2^ADDR_W)
//   dm_rd_data     - data memory read data, combinational from dm_rd_addr
//   busy           - high in RST, WAIT and READ
//   done           - high in DONE
//   pass_cnt       - number of matching words
//   fail_cnt       - number of mismatching words (NUM_TESTS on timeout)
//   first_fail_idx - index of the first mismatching word
//   first_fail_got - DM value read at the first mismatch
//   fail_seen      - at least one mismatch recorded
//   timeout_err    - cpu_ack not seen within TIMEOUT cycles
//   fail_map       - per-word mismatch bitmap (only with CPU_RESULT_CHECKER_FAIL_MAP_EN)
//
// Configuration macro:
//   CPU_RESULT_CHECKER_FAIL_MAP_EN - adds the fail_map output and its registers.

module cpu_result_checker #(
    parameter int NUM_TESTS  = 4,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int RES_BASE   = 10,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024,
    localparam int IDX_W     = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int CNT_W     = $clog2(NUM_TESTS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [DATA_W-1:0] exp_data,
    output logic              cpu_reset,
    output logic              cpu_start,
    input  logic              cpu_ack,
    output logic [ADDR_W-1:0] dm_rd_addr,
    input  logic [DATA_W-1:0] dm_rd_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_got,
    output logic              fail_seen,
    output logic              timeout_err
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
    ,
    output logic [NUM_TESTS-1:0] fail_map
`endif
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT,
        S_READ,
        S_DONE
    } state_t;

    state_t            state;
    logic [RW-1:0]     rst_cnt;
    logic [TW-1:0]     wait_cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] exp_mem [NUM_TESTS];

    logic idle_or_done;
    logic word_match;

    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign word_match   = (dm_rd_data == exp_mem[idx]);

    // Expected table survives reset so a campaign can be rerun without reloading.
    // Writing here on the go edge is harmless: READ is several cycles away.
    always_ff @(posedge clk) begin
        if (exp_we && idle_or_done && (int'(exp_idx) < NUM_TESTS)) begin
            exp_mem[exp_idx] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            rst_cnt        <= '0;
            wait_cnt       <= '0;
            idx            <= '0;
            cpu_reset      <= 1'b0;
            cpu_start      <= 1'b0;
            dm_rd_addr     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            fail_seen      <= 1'b0;
            timeout_err    <= 1'b0;
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
            fail_map       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state          <= S_RST;
                        rst_cnt        <= '0;
                        cpu_reset      <= 1'b1;
                        cpu_start      <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= '0;
                        first_fail_got <= '0;
                        fail_seen      <= 1'b0;
                        timeout_err    <= 1'b0;
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
                        fail_map       <= '0;
`endif
                    end
                end

                // cpu_reset/cpu_start were raised on the go edge, so they are
                // high for exactly RST_CYCLES cycles when dropped here.
                S_RST: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        state     <= S_WAIT;
                        wait_cnt  <= '0;
                        cpu_reset <= 1'b0;
                        cpu_start <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end

                // Ack takes priority over the timeout in the final WAIT cycle.
                S_WAIT: begin
                    if (cpu_ack) begin
                        state      <= S_READ;
                        idx        <= '0;
                        dm_rd_addr <= ADDR_W'(RES_BASE);
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        state       <= S_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        fail_cnt    <= CNT_W'(NUM_TESTS);
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
                        fail_map    <= '1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end

                // dm_rd_addr is registered one step ahead so it always equals
                // RES_BASE+idx while that word is being compared.
                S_READ: begin
                    if (word_match) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
                        fail_map[idx] <= 1'b1;
`endif
                        if (!fail_seen) begin
                            fail_seen      <= 1'b1;
                            first_fail_idx <= idx;
                            first_fail_got <= dm_rd_data;
                        end
                    end
                    if (idx == IDX_W'(NUM_TESTS - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx        <= idx + IDX_W'(1);
                        dm_rd_addr <= ADDR_W'(RES_BASE + int'(idx) + 1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_result_checker.sv
// tb/tb_cpu_result_checker.sv - directed self-checking bench for cpu_result_checker

module tb_cpu_result_checker;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int IW = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic exp_we = 1'b0;
    logic [IW-1:0] exp_idx = '0;
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] mem [256];

    // Instance a: result window at 10, instance b: window wrapping at 254.
    logic a_go = 1'b0, a_ack = 1'b0;
    logic a_cpu_reset, a_cpu_start, a_busy, a_done, a_fail_seen, a_timeout;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rd, a_ffg;
    logic [CW-1:0] a_pass, a_fail;
    logic [IW-1:0] a_ffi;
    logic b_go = 1'b0, b_ack = 1'b0;
    logic b_cpu_reset, b_cpu_start, b_busy, b_done, b_fail_seen, b_timeout;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rd, b_ffg;
    logic [CW-1:0] b_pass, b_fail;
    logic [IW-1:0] b_ffi;
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
    logic [N-1:0] a_map, b_map;
`endif

    assign a_rd = mem[a_addr];
    assign b_rd = mem[b_addr];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_result_checker #(.NUM_TESTS(N), .DATA_W(DW), .ADDR_W(AW), .RES_BASE(10),
                         .RST_CYCLES(2), .TIMEOUT(16)) u_a (
        .clk(clk), .reset(reset), .go(a_go), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_data(exp_data), .cpu_reset(a_cpu_reset), .cpu_start(a_cpu_start),
        .cpu_ack(a_ack), .dm_rd_addr(a_addr), .dm_rd_data(a_rd), .busy(a_busy),
        .done(a_done), .pass_cnt(a_pass), .fail_cnt(a_fail), .first_fail_idx(a_ffi),
        .first_fail_got(a_ffg), .fail_seen(a_fail_seen), .timeout_err(a_timeout)
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
        , .fail_map(a_map)
`endif
    );

    cpu_result_checker #(.NUM_TESTS(N), .DATA_W(DW), .ADDR_W(AW), .RES_BASE(254),
                         .RST_CYCLES(2), .TIMEOUT(16)) u_b (
        .clk(clk), .reset(reset), .go(b_go), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_data(exp_data), .cpu_reset(b_cpu_reset), .cpu_start(b_cpu_start),
        .cpu_ack(b_ack), .dm_rd_addr(b_addr), .dm_rd_data(b_rd), .busy(b_busy),
        .done(b_done), .pass_cnt(b_pass), .fail_cnt(b_fail), .first_fail_idx(b_ffi),
        .first_fail_got(b_ffg), .fail_seen(b_fail_seen), .timeout_err(b_timeout)
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
        , .fail_map(b_map)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_exp(input logic [DW-1:0] e0, e1, e2, e3);
        logic [DW-1:0] v [4];
        v = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            exp_we = 1'b1; exp_idx = IW'(i); exp_data = v[i];
            tick();
        end
        exp_we = 1'b0;
    endtask

    // Pulse go on instance a, acting as the CPU: ack k cycles into WAIT
    // (WAIT is recognised by cpu_reset having been seen high then low).
    // lat counts posedges from the one sampling go up to done visible.
    task automatic run_a(input int k, input bit do_ack, output int lat,
                         output int rsthi, output bit addr_nz);
        int w;
        bit seen;
        w = 0; seen = 0; rsthi = 0; addr_nz = 0;
        a_go = 1'b1;
        tick();
        a_go = 1'b0;
        lat = 1;
        while (!a_done && lat < 200) begin
            if (a_cpu_reset) begin
                rsthi++;
                seen = 1;
            end else if (seen && do_ack) begin
                if (w == k) a_ack = 1'b1;
                w++;
            end
            if (a_addr != 0) addr_nz = 1;
            tick();
            lat++;
        end
        if (a_addr != 0) addr_nz = 1;
        a_ack = 1'b0;
    endtask

    int lat, rsthi;
    bit addr_nz;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
        mem[10] = 70; mem[11] = 5; mem[12] = 253; mem[13] = 15;
        mem[254] = 9; mem[255] = 8; mem[0] = 7; mem[1] = 6;

        tick(); tick();
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_cpu_reset", a_cpu_reset, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_addr", a_addr, 0);
        reset = 1'b1;
        tick();

        // All-pass campaign, ack in first WAIT cycle.
        load_exp(70, 5, 253, 15);
        run_a(0, 1, lat, rsthi, addr_nz);
        chk("pass_done", a_done, 1);
        chk("pass_pass_cnt", a_pass, 4);
        chk("pass_fail_cnt", a_fail, 0);
        chk("pass_fail_seen", a_fail_seen, 0);
        chk("pass_latency", lat, 8);
        chk("pass_rst_cycles", rsthi, 2);
        chk("pass_busy_low", a_busy, 0);

        // One mismatch at word 2, later ack (k=3).
        mem[12] = 3;
        run_a(3, 1, lat, rsthi, addr_nz);
        chk("mis_latency", lat, 11);
        chk("mis_pass_cnt", a_pass, 3);
        chk("mis_fail_cnt", a_fail, 1);
        chk("mis_ffi", a_ffi, 2);
        chk("mis_ffg", a_ffg, 3);
        chk("mis_fail_seen", a_fail_seen, 1);
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
        chk("mis_map", a_map, 4'b0100);
`endif
        mem[12] = 253;

        // Write and go in the same cycle: the new exp[0] applies to this run.
        exp_we = 1'b1; exp_idx = 0; exp_data = 71;
        a_go = 1'b1;
        tick();
        a_go = 1'b0; exp_we = 1'b0;
        tick(); tick();
        a_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        a_ack = 1'b0;
        chk("wg_done", a_done, 1);
        chk("wg_fail_cnt", a_fail, 1);
        chk("wg_ffi", a_ffi, 0);
        chk("wg_ffg", a_ffg, 70);
        exp_we = 1'b1; exp_idx = 0; exp_data = 70;
        tick();
        exp_we = 1'b0;

        // Timeout from a fresh reset so dm_rd_addr starts at 0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run_a(0, 0, lat, rsthi, addr_nz);
        chk("to_latency", lat, 19);
        chk("to_timeout_err", a_timeout, 1);
        chk("to_fail_cnt", a_fail, 4);
        chk("to_pass_cnt", a_pass, 0);
        chk("to_addr_zero", addr_nz, 0);
`ifdef CPU_RESULT_CHECKER_FAIL_MAP_EN
        chk("to_map", a_map, 4'b1111);
`endif

        // Reset while comparing word 1; table must survive.
        a_go = 1'b1;
        tick();
        a_go = 1'b0;
        tick(); tick();
        a_ack = 1'b1;
        tick();
        chk("mr_addr_idx0", a_addr, 10);
        tick();
        chk("mr_addr_idx1", a_addr, 11);
        chk("mr_pass_before", a_pass, 1);
        reset = 1'b0;
        tick();
        chk("mr_busy", a_busy, 0);
        chk("mr_done", a_done, 0);
        chk("mr_pass", a_pass, 0);
        chk("mr_cpu_reset", a_cpu_reset, 0);
        chk("mr_addr", a_addr, 0);
        reset = 1'b1;
        a_ack = 1'b0;
        tick();
        run_a(0, 1, lat, rsthi, addr_nz);
        chk("mr_rerun_pass", a_pass, 4);
        chk("mr_rerun_timeout", a_timeout, 0);

        // Instance b: address wrap, go pulses while busy ignored.
        load_exp(9, 8, 7, 6);
        b_go = 1'b1;
        tick();
        b_go = 1'b0;
        tick();
        b_go = 1'b1;
        tick();
        b_go = 1'b0;
        chk("wr_rst_dropped", b_cpu_reset, 0);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk("wr_addr0", b_addr, 254);
        b_go = 1'b1;
        tick();
        b_go = 1'b0;
        chk("wr_addr1", b_addr, 255);
        chk("wr_busy_go_ignored", b_cpu_reset, 0);
        tick();
        chk("wr_addr2", b_addr, 0);
        tick();
        chk("wr_addr3", b_addr, 1);
        tick();
        chk("wr_done", b_done, 1);
        chk("wr_pass", b_pass, 4);
        chk("wr_fail", b_fail, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_result_checker.md
Name: cpu_result_checker

Overview:
- Hardware self-test sequencer for the CPU.
- Resets and launches the CPU with the same handshake the bench uses: reset and start are held together, then both drop, then the block waits for ack.
- After ack, reads a contiguous result window of data memory and compares each word against a loadable expected table.
- Reports pass/fail counts and the first mismatch; sits beside the CPU and DM1 read port in the test top.

Parameters:
- NUM_TESTS, 4, number of result words checked; must be at least 1.
- DATA_W, 8, data memory word width.
- ADDR_W, 8, data memory address width.
- RES_BASE, 10, DM address of result word 0.
- RST_CYCLES, 2, cycles that cpu_reset/cpu_start are held high; must be at least 1.
- TIMEOUT, 1024, maximum cycles to wait for cpu_ack.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- reset, in, 1, synchronous active-low reset.
- go, in, 1, single-cycle request to run a campaign; honoured only in IDLE or DONE.
- exp_we, in, 1, expected-table write enable; ignored unless in IDLE or DONE.
- exp_idx, in, clog2(NUM_TESTS) (minimum 1), expected-table write index.
- exp_data, in, DATA_W, expected value to write.
- cpu_reset, out, 1, active-high reset to CPU.
- cpu_start, out, 1, start request to CPU.
- cpu_ack, in, 1, CPU program-complete flag.
- dm_rd_addr, out, ADDR_W, data memory read address.
- dm_rd_data, in, DATA_W, data memory read data; combinational, valid in the same cycle.
- busy, out, 1, high in every state except IDLE and DONE.
- done, out, 1, high in DONE.
- pass_cnt, out, clog2(NUM_TESTS+1), matching words.
- fail_cnt, out, clog2(NUM_TESTS+1), mismatching words.
- first_fail_idx, out, clog2(NUM_TESTS) (minimum 1), index of the first mismatch.
- first_fail_got, out, DATA_W, DM value at the first mismatch.
- fail_seen, out, 1, at least one mismatch recorded.
- timeout_err, out, 1, ack was not seen within TIMEOUT cycles.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - All outputs 0, including dm_rd_addr, first_fail_idx and first_fail_got.
  - Expected table is not cleared.
  - Reset mid-campaign aborts immediately; cpu_reset/cpu_start drop on the next cycle.
- Expected table: NUM_TESTS x DATA_W registers, written on posedge when exp_we is high in IDLE or DONE. A write and go in the same cycle: the write lands first and is visible to that campaign.
- FSM:
  - IDLE: on go, clear pass_cnt, fail_cnt, fail_seen, timeout_err, first_fail_*; go to RST.
  - RST: cpu_reset=1, cpu_start=1 for exactly RST_CYCLES cycles, then go to WAIT.
  - WAIT: cpu_reset=0, cpu_start=0; cycle counter starts at 0.
    - cpu_ack=1 goes to READ with idx=0.
    - Counter reaching TIMEOUT-1 without ack sets timeout_err=1, fail_cnt=NUM_TESTS, and goes to DONE.
    - cpu_ack sampled high in the first WAIT cycle is accepted.
  - READ: one word per cycle. dm_rd_addr=RES_BASE+idx, truncated to ADDR_W, so addresses wrap modulo 2^ADDR_W. Compare dm_rd_data against exp[idx]:
    - Equal: pass_cnt++.
    - Not equal: fail_cnt++; if fail_seen==0, capture first_fail_idx=idx and first_fail_got=dm_rd_data, then set fail_seen=1.
    - After idx==NUM_TESTS-1, go to DONE. READ lasts exactly NUM_TESTS cycles.
  - DONE: done=1; results held stable. go restarts the campaign as from IDLE (done drops on the next cycle).
- go while busy is ignored.
- Comparison is exact bitwise over DATA_W; no signed interpretation.
- Invariant in DONE: pass_cnt+fail_cnt==NUM_TESTS.
- Latency with ack at WAIT cycle k (k=0 first): go to done = 1 + RST_CYCLES + (k+1) + NUM_TESTS cycles.

Optional Feature:
- Macro: CPU_RESULT_CHECKER_FAIL_MAP_EN.
- Defined: adds output fail_map[NUM_TESTS-1:0].
  - Bit i is set when word i mismatches; cleared on go and on reset.
  - On timeout, all bits are set.
- Undefined: port absent, no map registers; all other behaviour identical.

Test Plan:
- Preload exp={70,5,253,15}; CPU stores 70,5,253,15 at DM[10..13] then raises ack; pulse go -> done=1, pass_cnt=4, fail_cnt=0, fail_seen=0.
- Same run with DM[12]=3 instead of 253 -> pass_cnt=3, fail_cnt=1, first_fail_idx=2, first_fail_got=3; with macro, fail_map=4'b0100.
- Hold cpu_ack=0, TIMEOUT=16 -> timeout_err=1 exactly 1+RST_CYCLES+16 cycles after go; fail_cnt=4; READ never entered; dm_rd_addr stays 0.
- RST_CYCLES=2, ack at first WAIT cycle -> cpu_reset/cpu_start high exactly 2 cycles; done rises 8 cycles after go.
- Assert reset=0 during READ at idx=1 -> next cycle busy=0, done=0, counts 0, cpu_reset=0; exp table retained; a new go with no re-load passes 4/4.
- RES_BASE=254, ADDR_W=8 -> dm_rd_addr sequence 254, 255, 0, 1; go pulsed while busy has no effect.
